// File: rtl/signed_sub_serial_pkg.sv
// ============================================================================
// Module   : signed_sub_pkg
// Brief    : Shared types for the bit-serial signed subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package signed_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/signed_sub_serial_if.sv
// ============================================================================
// Module   : signed_sub_serial_if
// Brief    : Operand/result ready-valid bundle for the serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface signed_sub_serial_if #(
    parameter int WIDTH = 8
);

    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             res_vld;
    logic             res_rdy;
    logic [WIDTH-1:0] diff;
    logic             overflow;

    modport master (
        output in_vld, a, b, res_rdy,
        input  in_rdy, res_vld, diff, overflow
    );

    modport slave (
        input  in_vld, a, b, res_rdy,
        output in_rdy, res_vld, diff, overflow
    );

endinterface

`default_nettype wire

// File: rtl/signed_sub_serial_fa.sv
// ============================================================================
// Module   : serial_full_adder_bit
// Brief    : 1-bit combinational sum/carry cell; the carry flop lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_full_adder_bit (
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic c_i,
    output logic      s_o,
    output logic      c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

`default_nettype wire

// File: rtl/signed_sub_serial.sv
// ============================================================================
// Module   : signed_sub_serial
// Brief    : Bit-serial two's-complement a-b, LSB first, with overflow flag.
//            Define SIGNED_SUB_SATURATE_EN to saturate diff on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_sub_serial
    import signed_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    signed_sub_serial_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] nb_sh_q, nb_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             ovf_q, ovf_d;

    logic             w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_wrap;

    serial_full_adder_bit u_fa (
        .a_i (a_sh_q[0]),
        .b_i (nb_sh_q[0]),
        .c_i (carry_q),
        .s_o (w_sum),
        .c_o (w_cout)
    );

    // Only meaningful on the MSB cycle: carry-in vs carry-out of the sign bit.
    assign w_ovf  = carry_q ^ w_cout;
    assign w_wrap = {w_sum, res_sh_q[WIDTH-1:1]};

`ifdef SIGNED_SUB_SATURATE_EN
    logic [WIDTH-1:0] w_sat;
    // On the last bit a_sh_q[0] is the minuend's sign bit.
    assign w_sat = {a_sh_q[0], {(WIDTH-1){~a_sh_q[0]}}};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            nb_sh_q  <= '0;
            res_sh_q <= '0;
            diff_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            nb_sh_q  <= nb_sh_d;
            res_sh_q <= res_sh_d;
            diff_q   <= diff_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        nb_sh_d  = nb_sh_q;
        res_sh_d = res_sh_q;
        diff_d   = diff_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_vld) begin
                    a_sh_d  = bus.a;
                    nb_sh_d = ~bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_sh_d = w_wrap;
                a_sh_d   = a_sh_q >> 1;
                nb_sh_d  = nb_sh_q >> 1;
                carry_d  = w_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    ovf_d   = w_ovf;
`ifdef SIGNED_SUB_SATURATE_EN
                    diff_d  = w_ovf ? w_sat : w_wrap;
`else
                    diff_d  = w_wrap;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_rdy   = (state_q == IDLE);
    assign bus.res_vld  = (state_q == DONE);
    assign bus.diff     = diff_q;
    assign bus.overflow = ovf_q;

endmodule

`default_nettype wire
